// File: rtl/prbs7_xnor_checker_if.sv
// Link-test PRBS-7 checker bus: bit stream in, lock/error status out.
// master: drives en, din_valid, din, clr_err; samples locked, err_pulse, err_count.
// slave : the checker itself.
interface prbs7_xnor_checker_if #(
  parameter int ERR_CNT_W = 16
);
  logic                 en;
  logic                 din_valid;
  logic                 din;
  logic                 clr_err;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output en, din_valid, din, clr_err,
    input  locked, err_pulse, err_count
  );

  modport slave (
    input  en, din_valid, din, clr_err,
    output locked, err_pulse, err_count
  );
endinterface

// File: rtl/prbs7_xnor_checker.sv
// Serial PRBS-7 (x^7+x^6+1, XNOR feedback) checker: self-syncs, locks, counts bit errors.
// Latency: din to locked/err_pulse is 1 clk. No backpressure; din_valid=0 simply stalls all state.
// Ports: clk, rst_n (async active-low), bus (slave: en, din_valid, din, clr_err -> locked, err_pulse, err_count).
module prbs7_xnor_checker #(
  parameter int ERR_CNT_W = 16,
  parameter int LOCK_BITS = 16,
  parameter int WINDOW    = 64,
  parameter int LOSS_ERRS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  prbs7_xnor_checker_if.slave   bus
);

  localparam int WB_W = $clog2(WINDOW);
  localparam int WE_W = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {IDLE, FILL, SYNC, LOCK} state_t;

  state_t               r_state, w_state_nxt;
  logic [6:0]           r_hist, w_hist_nxt;      // h[0] newest bit
  logic [2:0]           r_fill, w_fill_nxt;
  logic [7:0]           r_match, w_match_nxt;
  logic [WB_W-1:0]      r_wbits, w_wbits_nxt;
  logic [WE_W-1:0]      r_werrs, w_werrs_nxt;
  logic                 r_locked, w_locked_nxt;
  logic                 r_err_pulse, w_err_pulse_nxt;
  logic [ERR_CNT_W-1:0] r_err_count, w_err_count_nxt;

  logic                 w_pred;
  logic                 w_err;
  logic [WE_W-1:0]      w_werrs_acc;

  assign w_pred = r_hist[6] ~^ r_hist[5];

  always_comb begin
    w_state_nxt     = r_state;
    w_hist_nxt      = r_hist;
    w_fill_nxt      = r_fill;
    w_match_nxt     = r_match;
    w_wbits_nxt     = r_wbits;
    w_werrs_nxt     = r_werrs;
    w_locked_nxt    = r_locked;
    w_err_pulse_nxt = 1'b0;
    w_err_count_nxt = r_err_count;
    w_err           = 1'b0;
    w_werrs_acc     = '0;

    case (r_state)
      IDLE: begin
        // A valid bit on the leaving edge is already the first fill bit.
        w_state_nxt = FILL;
        if (bus.din_valid) begin
          w_hist_nxt = {r_hist[5:0], bus.din};
          w_fill_nxt = 3'd1;
        end
      end
      FILL: begin
        if (bus.din_valid) begin
          w_hist_nxt = {r_hist[5:0], bus.din};
          if (r_fill == 3'd6) begin
            w_state_nxt = SYNC;
            w_fill_nxt  = '0;
            w_match_nxt = '0;
          end else begin
            w_fill_nxt = r_fill + 3'd1;
          end
        end
      end
      SYNC: begin
        if (bus.din_valid) begin
          w_hist_nxt = {r_hist[5:0], bus.din};
          // All-ones history is the XNOR lockup state; it predicts itself forever.
          if ((bus.din == w_pred) && (r_hist != 7'h7F)) begin
            if (r_match == 8'(LOCK_BITS - 1)) begin
              w_state_nxt  = LOCK;
              w_locked_nxt = 1'b1;
              w_match_nxt  = '0;
              w_wbits_nxt  = '0;
              w_werrs_nxt  = '0;
            end else begin
              w_match_nxt = r_match + 8'd1;
            end
          end else begin
            w_match_nxt = '0;
          end
        end
      end
      LOCK: begin
        if (bus.din_valid) begin
          // Free-run on the prediction so one line error is counted once.
          w_hist_nxt      = {r_hist[5:0], w_pred};
          w_err           = (bus.din != w_pred);
          w_err_pulse_nxt = w_err;
          if (r_wbits == WB_W'(WINDOW - 1)) begin
            w_wbits_nxt = '0;
            w_werrs_acc = WE_W'(w_err);
          end else begin
            w_wbits_nxt = r_wbits + WB_W'(1);
            w_werrs_acc = r_werrs + WE_W'(w_err);
          end
          w_werrs_nxt = w_werrs_acc;
          if (w_err && (w_werrs_acc == WE_W'(LOSS_ERRS))) begin
            w_state_nxt  = FILL;
            w_locked_nxt = 1'b0;
            w_fill_nxt   = '0;
            w_wbits_nxt  = '0;
            w_werrs_nxt  = '0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Disable wins over everything; the error count survives it.
    if (!bus.en) begin
      w_state_nxt     = IDLE;
      w_hist_nxt      = r_hist;
      w_locked_nxt    = 1'b0;
      w_fill_nxt      = '0;
      w_match_nxt     = '0;
      w_wbits_nxt     = '0;
      w_werrs_nxt     = '0;
      w_err_pulse_nxt = 1'b0;
      w_err           = 1'b0;
    end

    // Clear and a same-cycle error combine so the error is never lost.
    if (bus.clr_err) begin
      w_err_count_nxt = ERR_CNT_W'(w_err);
    end else if (w_err && (r_err_count != '1)) begin
      w_err_count_nxt = r_err_count + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_hist      <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_wbits     <= '0;
      r_werrs     <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hist      <= w_hist_nxt;
      r_fill      <= w_fill_nxt;
      r_match     <= w_match_nxt;
      r_wbits     <= w_wbits_nxt;
      r_werrs     <= w_werrs_nxt;
      r_locked    <= w_locked_nxt;
      r_err_pulse <= w_err_pulse_nxt;
      r_err_count <= w_err_count_nxt;
    end
  end

  assign bus.locked    = r_locked;
  assign bus.err_pulse = r_err_pulse;
  assign bus.err_count = r_err_count;

endmodule

// File: doc/prbs7_xnor_checker.md
Name: prbs7_xnor_checker

Overview:
- Serial PRBS-7 pattern checker for the link test path. It is the receive end of the team's XNOR-feedback PRBS-7 generator.
- Generator polynomial is x^7 + x^6 + 1 with XNOR feedback: bit b[n] = b[n-7] ~^ b[n-6].
- The block self-synchronises to an incoming bit stream, declares lock, then counts bit errors against its internal prediction.
- It sits between the deserialiser/loopback output and the status registers.

Parameters:
- ERR_CNT_W, 16, width of the saturating error counter.
- LOCK_BITS, 16, consecutive matching bits in SYNC required to declare lock (range 1..255).
- WINDOW, 64, valid-bit window length used for loss-of-lock detection (range 2..1023).
- LOSS_ERRS, 4, errors within one window that force loss of lock (range 1..WINDOW).

Ports:
- clk  input  1  Single clock; all state changes on its rising edge.
- rst_n  input  1  Reset, asynchronous assert, active-low.
- en  input  1  Checker enable; 0 forces IDLE.
- din_valid  input  1  Qualifies din; the bit is consumed on a cycle where din_valid=1.
- din  input  1  Received serial bit.
- clr_err  input  1  Synchronous clear of err_count.
- locked  output  1  Registered lock status.
- err_pulse  output  1  One-cycle registered pulse per detected bit error.
- err_count  output  ERR_CNT_W  Saturating count of detected errors since the last reset or clear.

Behaviour:
- Reset (rst_n=0, asynchronous): locked=0, err_pulse=0, err_count=0, history h[6:0]=0, all internal counters=0, state=IDLE.
- Prediction: p = h[6] ~^ h[5], where h[0] is the newest bit. Shift is h <= {h[5:0], x}. Only a valid bit advances any state, shift or counter; din_valid=0 holds everything (err_pulse=0).
- State IDLE:
  - Entered whenever en=0, from any state in the same cycle edge. On entry: locked=0 and fill, match and window counters cleared. err_count is retained.
  - en=1 -> FILL.
- State FILL: shift din into h for 7 valid bits, then -> SYNC.
- State SYNC: for each valid bit, shift din into h (x=din).
  - Match counter increments if din==p and h!=7'h7F.
  - Otherwise the match counter returns to 0. All-ones is the XNOR lockup state and never counts toward lock.
  - On the LOCK_BITS-th consecutive match: -> LOCK, and locked=1 on that same edge (visible the cycle after the bit).
  - No errors are counted in FILL or SYNC.
- State LOCK: for each valid bit, shift p into h (x=p; the free-running prediction avoids error multiplication).
  - din!=p: err_pulse=1 next cycle, err_count+1 (saturates at 2^ERR_CNT_W-1), window error counter +1.
  - Window bit counter counts valid bits 0..WINDOW-1. At wrap, the window error counter clears; an error on the wrapping bit counts into the new window as 1.
  - Window error counter reaching LOSS_ERRS: locked=0 on that same edge, then -> FILL. The triggering error is still counted and pulsed.
- clr_err=1: err_count becomes 0. If an error is detected on the same cycle, err_count becomes 1; no error is lost.
- rst_n deassertion: synchronous to clk per team reset-sync practice. The first valid bit is accepted on the first edge after rst_n=1.
- Latency: din to err_pulse/locked is exactly 1 clk.

Test Plan:
- Reset:
  - Stimulus: drive rst_n=0 mid-LOCK with errors counted.
  - Response: locked, err_pulse and err_count go 0 immediately, without a clk edge.
  - Stimulus: release rst_n with en=1 and a clean stream.
  - Response: relock after 23 valid bits.
- Clean lock:
  - Stimulus: en=1, generator seeded 7'h00, din_valid=1 continuously.
  - Response: locked rises 1 cycle after valid bit 23 (7 FILL + 16 SYNC). err_count=0 after 2000 bits.
  - Repeat with din_valid toggling 1/0 pseudo-randomly: lock still occurs after exactly 23 valid bits.
- Single error:
  - Stimulus: flip bit 300 of a locked stream.
  - Response: exactly one err_pulse, on the cycle after bit 300. err_count=1, locked stays 1.
- Loss of lock:
  - Stimulus: flip 4 bits within one 64-bit window.
  - Response: err_count=4, locked falls with the 4th pulse, relock after 23 further clean bits.
  - Stimulus: flip 3 bits per window indefinitely.
  - Response: locked never drops.
- Lockup pattern:
  - Stimulus: 500 consecutive 1s with en=1.
  - Response: locked stays 0 and err_count stays 0.
- Saturation and clear (ERR_CNT_W=4, LOSS_ERRS=64, WINDOW=64):
  - Stimulus: inject 20 isolated errors.
  - Response: err_count=15 and 20 err_pulses.
  - Stimulus: assert clr_err on an error cycle.
  - Response: err_count=1.
  - Stimulus: assert en=0 for 1 cycle.
  - Response: locked=0, err_count retained.
